// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states and fault codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Counts cycles spent waiting on memory; expired marks the last allowed BUSY cycle.
module lsu_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The count is 0 during the first BUSY cycle, so TIMEOUT-1 is the final one.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: req/ack to memory, core stall, load writeback pulse, faults.
// Handshake: mem_req rises with BUSY and stays high with stable we/addr/wdata until the cycle mem_ack is seen.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_read,
    input  logic              ex_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [3:0]        ex_dest,
    output logic              stall,
    output logic              wb_valid,
    output logic [3:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              ls_done,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        dest_q, dest_d;
    logic [3:0]        wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic              busy, expired;

    assign busy = (state_q == ST_BUSY);

    lsu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (busy),
        .clr     (!busy || mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dest_d       = dest_q;
        wb_reg_d     = wb_reg_q;
        wb_data_d    = wb_data_q;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;
        stall        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_read || ex_write) begin
                    stall   = 1'b1;
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    dest_d  = ex_dest;
                    we_d    = ex_write;
                    if (ex_addr[1:0] != 2'b00) begin
                        fault_d      = 1'b1;
                        fault_code_d = FAULT_MISALIGN;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        wb_reg_d  = dest_q;
                        wb_data_d = mem_rdata;
                    end
                end else if (expired) begin
                    state_d      = ST_IDLE;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dest_q       <= '0;
            wb_reg_q     <= '0;
            wb_data_q    <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dest_q       <= dest_d;
            wb_reg_q     <= wb_reg_d;
            wb_data_q    <= wb_data_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign mem_req    = busy;
    assign mem_we     = busy && we_q;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = wdata_q;
    assign ls_done    = (state_q == ST_DONE);
    assign wb_valid   = (state_q == ST_DONE) && !we_q;
    assign wb_reg     = wb_reg_q;
    assign wb_data    = wb_data_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: cycle-by-cycle checks of loads, stores, faults and reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_read, ex_write;
    logic [31:0] ex_addr, ex_wdata;
    logic [3:0]  ex_dest;
    logic        stall, wb_valid, ls_done, fault, mem_req, mem_we, mem_ack;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  fault_code, dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_read    (ex_read),
        .ex_write   (ex_write),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_dest    (ex_dest),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .ls_done    (ls_done),
        .fault      (fault),
        .fault_code (fault_code),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Advance to just after the next rising edge; inputs change only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_read = 1'b0; ex_write = 1'b0; ex_addr = '0; ex_wdata = '0; ex_dest = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0; clear_ex();
        repeat (3) tick();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if ({wb_valid, ls_done, fault} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {wb_valid, ls_done, fault}); end
        checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL reset_fault_code: got %b want 00", fault_code); end
        checks++; if (mem_addr !== 32'h0 || wb_data !== 32'h0) begin errors++; $display("FAIL reset_data: addr %h wb_data %h want 0", mem_addr, wb_data); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Load to 0x100, ack in the third BUSY cycle, writeback in cycle 4.
    task automatic test_load();
        ex_read = 1'b1; ex_addr = 32'h100; ex_dest = 4'd5;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_c0_stall: got %b want 1", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load_c0_req: got %b want 0", mem_req); end
        tick(); clear_ex();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL load_c%0d_busy: req %b stall %b want 1 1", c, mem_req, stall); end
            checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin errors++; $display("FAIL load_c%0d_bus: addr %h we %b want 100 0", c, mem_addr, mem_we); end
            tick(); mem_ack = 1'b0; mem_rdata = '0;
        end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || ls_done !== 1'b1) begin errors++; $display("FAIL load_c4_pulse: wb_valid %b ls_done %b want 1 1", wb_valid, ls_done); end
        checks++; if (wb_reg !== 4'd5 || wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_c4_wb: reg %0d data %h want 5 deadbeef", wb_reg, wb_data); end
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL load_c4_idle: stall %b req %b want 0 0", stall, mem_req); end
        tick();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL load_c5_pulse: wb_valid %b ls_done %b want 0 0", wb_valid, ls_done); end
        checks++; if (wb_data !== 32'hDEADBEEF || wb_reg !== 4'd5) begin errors++; $display("FAIL load_c5_hold: reg %0d data %h want 5 deadbeef", wb_reg, wb_data); end
        tick();
    endtask

    // Store with ack in the first BUSY cycle; writeback registers must keep the last load.
    task automatic test_store();
        ex_write = 1'b1; ex_addr = 32'h40; ex_wdata = 32'h1234; ex_dest = 4'd9;
        tick(); clear_ex();
        mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL store_c1_req: req %b we %b want 1 1", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL store_c1_bus: addr %h wdata %h want 40 1234", mem_addr, mem_wdata); end
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL store_c2_done: ls_done %b wb_valid %b want 1 0", ls_done, wb_valid); end
        checks++; if (mem_we !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_c2_bus: we %b req %b want 0 0", mem_we, mem_req); end
        checks++; if (wb_reg !== 4'd5 || wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL store_c2_hold: reg %0d data %h want 5 deadbeef", wb_reg, wb_data); end
        tick();
    endtask

    task automatic test_misaligned();
        ex_read = 1'b1; ex_addr = 32'h102; ex_dest = 4'd2;
        @(negedge clk);
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_c0: stall %b req %b want 1 0", stall, mem_req); end
        tick(); clear_ex();
        @(negedge clk);
        checks++; if (fault !== 1'b1 || fault_code !== 2'b01) begin errors++; $display("FAIL mis_c1_fault: fault %b code %b want 1 01", fault, fault_code); end
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL mis_c1_quiet: stall %b req %b done %b want 000", stall, mem_req, ls_done); end
        tick();
        @(negedge clk);
        checks++; if (fault !== 1'b0 || fault_code !== 2'b01) begin errors++; $display("FAIL mis_c2_hold: fault %b code %b want 0 01", fault, fault_code); end
        tick();
    endtask

    // No ack: mem_req high for exactly 15 cycles, timeout fault in cycle 16.
    task automatic test_timeout();
        int req_cycles = 0;
        ex_read = 1'b1; ex_addr = 32'h200; ex_dest = 4'd7;
        tick(); clear_ex();
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) req_cycles++;
            tick();
        end
        checks++; if (req_cycles != 15) begin errors++; $display("FAIL tmo_req_len: got %0d want 15", req_cycles); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || fault !== 1'b1 || fault_code !== 2'b10) begin errors++; $display("FAIL tmo_c16: req %b fault %b code %b want 0 1 10", mem_req, fault, fault_code); end
        checks++; if (wb_valid !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL tmo_c16_nowb: wb_valid %b ls_done %b want 0 0", wb_valid, ls_done); end
        tick();
        @(negedge clk);
        checks++; if (fault !== 1'b0 || fault_code !== 2'b10) begin errors++; $display("FAIL tmo_c17_hold: fault %b code %b want 0 10", fault, fault_code); end
        tick();
    endtask

    task automatic test_reset_busy();
        ex_read = 1'b1; ex_addr = 32'h300; ex_dest = 4'd4;
        tick(); clear_ex();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rstb_c3: req %b stall %b want 0 0", mem_req, stall); end
        checks++; if ({wb_valid, ls_done, fault} !== 3'b000 || fault_code !== 2'b00) begin errors++; $display("FAIL rstb_c3_out: pulses %b code %b want 000 00", {wb_valid, ls_done, fault}, fault_code); end
        tick(); mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        checks++; if ({mem_req, wb_valid, ls_done} !== 3'b000 || wb_data !== 32'h0) begin errors++; $display("FAIL rstb_c4_late_ack: req/wb/done %b wb_data %h want 000 0", {mem_req, wb_valid, ls_done}, wb_data); end
        tick();
    endtask

    task automatic test_read_write();
        ex_read = 1'b1; ex_write = 1'b1; ex_addr = 32'h8; ex_wdata = 32'hA5A5_5A5A; ex_dest = 4'd3;
        tick(); clear_ex();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hA5A5_5A5A || mem_addr !== 32'h8) begin errors++; $display("FAIL rw_c1: we %b wdata %h addr %h want 1 a5a55a5a 8", mem_we, mem_wdata, mem_addr); end
        tick(); mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL rw_c2: ls_done %b wb_valid %b want 1 0", ls_done, wb_valid); end
        tick();
    endtask

    // Request held through DONE is taken only after the bubble cycle.
    task automatic test_back_to_back();
        ex_read = 1'b1; ex_addr = 32'hFFFF_FFFC; ex_dest = 4'd12;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        checks++; if (mem_addr !== 32'hFFFF_FFFC || mem_req !== 1'b1) begin errors++; $display("FAIL b2b_c1: addr %h req %b want fffffffc 1", mem_addr, mem_req); end
        tick(); mem_ack = 1'b0; mem_rdata = '0; ex_addr = 32'h20; ex_dest = 4'd1;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || stall !== 1'b0 || wb_reg !== 4'd12 || wb_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_c2_done: wb %b stall %b reg %0d data %h want 1 0 12 0badf00d", wb_valid, stall, wb_reg, wb_data); end
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_c3_bubble: stall %b req %b want 1 0", stall, mem_req); end
        tick(); clear_ex();
        mem_ack = 1'b1; mem_rdata = 32'h7777_0001;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL b2b_c4_req: req %b addr %h want 1 20", mem_req, mem_addr); end
        tick(); mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd1 || wb_data !== 32'h7777_0001) begin errors++; $display("FAIL b2b_c5_wb: wb %b reg %0d data %h want 1 1 77770001", wb_valid, wb_reg, wb_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_read_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
